// File: rtl/grf.sv
// General register file: 32 x 32-bit, two combinational read ports, one synchronous write port.
// Register $0 has no storage and always reads zero; optional write-first bypass on both read ports.
module grf #(
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  input  logic [4:0]  WA,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WCNT
);

  logic [31:0] regs_q [1:31];
  logic [31:0] wcnt_q;
  logic        wr_hit;

  // A write commits only outside reset and never to $0.
  assign wr_hit = !reset && WE && (WA != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      wcnt_q <= 32'd0;
    end else if (wr_hit) begin
      regs_q[WA] <= WD;
      wcnt_q     <= wcnt_q + 32'd1;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] ra, input logic [31:0] stored);
    logic [31:0] val;
    val = stored;
    if (ra == 5'd0) begin
      val = 32'd0;
    end else if (BYPASS && wr_hit && (ra == WA)) begin
      val = WD;
    end
    return val;
  endfunction

  logic [31:0] stored1;
  logic [31:0] stored2;

  always_comb begin
    stored1 = 32'd0;
    stored2 = 32'd0;
    if (RA1 != 5'd0) stored1 = regs_q[RA1];
    if (RA2 != 5'd0) stored2 = regs_q[RA2];
  end

  assign RD1  = read_port(RA1, stored1);
  assign RD2  = read_port(RA2, stored2);
  assign WCNT = wcnt_q;

endmodule

// File: tb/tb_grf.sv
// Randomized self-checking bench for grf: bypass and non-bypass instances against an array model.
module tb_grf;

  localparam logic [31:0] RV_N = 32'h1234_5678;

  logic        clk;
  logic        reset;
  logic [4:0]  RA1, RA2, WA;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] rd1_b, rd2_b, wcnt_b;
  logic [31:0] rd1_n, rd2_n, wcnt_n;

  int checks;
  int failures;
  bit rst_seen;

  logic [31:0] mem_b [32];
  logic [31:0] mem_n [32];
  logic [31:0] cnt_m;

  grf #(.BYPASS(1'b1), .RESET_VAL(32'h0000_0000)) u_byp (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .WA(WA), .WD(WD), .WE(WE),
    .RD1(rd1_b), .RD2(rd2_b), .WCNT(wcnt_b)
  );

  grf #(.BYPASS(1'b0), .RESET_VAL(RV_N)) u_nob (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .WA(WA), .WD(WD), .WE(WE),
    .RD1(rd1_n), .RD2(rd2_n), .WCNT(wcnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference read: $0 first, then write-first forwarding (never during reset), else storage.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'd0;
    if (byp && !reset && WE && WA != 5'd0 && WA == ra) return WD;
    return byp ? mem_b[ra] : mem_n[ra];
  endfunction

  task automatic compare_all();
    if (!rst_seen) return;
    checks++;
    if ($isunknown({rd1_b, rd2_b, rd1_n, rd2_n})) begin
      failures++;
      $display("FAIL x_on_rd actual=%h_%h_%h_%h required=no_x", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    chk("cyc_rd1_byp", rd1_b, exp_rd(RA1, 1'b1));
    chk("cyc_rd2_byp", rd2_b, exp_rd(RA2, 1'b1));
    chk("cyc_rd1_nob", rd1_n, exp_rd(RA1, 1'b0));
    chk("cyc_rd2_nob", rd2_n, exp_rd(RA2, 1'b0));
    chk("cyc_wcnt_byp", wcnt_b, cnt_m);
    chk("cyc_wcnt_nob", wcnt_n, cnt_m);
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        mem_b[i] = 32'h0;
        mem_n[i] = RV_N;
      end
      cnt_m    = 32'd0;
      rst_seen = 1'b1;
    end else if (WE && WA != 5'd0) begin
      mem_b[WA] = WD;
      mem_n[WA] = WD;
      cnt_m     = cnt_m + 32'd1;
    end
  endtask

  // Inputs are held from posedge+1 to the next posedge; outputs compared on the negedge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    reset = r; WE = we; WA = wa; WD = wd; RA1 = ra1; RA2 = ra2;
  endtask

  initial begin
    logic [31:0] v1, v2;
    checks = 0; failures = 0; rst_seen = 1'b0; cnt_m = 32'd0;
    for (int i = 0; i < 32; i++) begin
      mem_b[i] = 32'h0;
      mem_n[i] = 32'h0;
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(posedge clk); #1;

    // Reset then read.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    #1;
    chk("rst_rd1", rd1_b, 32'd0);
    chk("rst_rd2", rd2_b, 32'd0);
    chk("rst_wcnt", wcnt_b, 32'd0);
    chk("rst_rd1_resetval", rd1_n, 32'h1234_5678);

    // Write and read back; ALU add / sub of the operands.
    drive(1'b0, 1'b1, 5'd1, 32'd10, 5'd5, 5'd31);
    tick();
    drive(1'b0, 1'b1, 5'd2, 32'd100, 5'd5, 5'd31);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    #1;
    chk("wr_rd1", rd1_b, 32'd10);
    chk("wr_rd2", rd2_b, 32'd100);
    chk("wr_wcnt", wcnt_b, 32'd2);
    chk("alu_add", rd1_b + rd2_b, 32'd110);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    #1;
    chk("alu_sub", rd1_n - rd2_n, 32'd90);

    // Writes to $0 are dropped.
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    #1;
    chk("r0_bypass", rd1_b, 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    chk("r0_rd1", rd1_b, 32'd0);
    chk("r0_wcnt", wcnt_b, 32'd2);

    // Bypass vs. no bypass.
    drive(1'b0, 1'b1, 5'd3, 32'd5, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd3, 32'hA600_0000, 5'd3, 5'd3);
    #1;
    chk("byp_rd1_pre", rd1_b, 32'hA600_0000);
    chk("byp_rd2_pre", rd2_b, 32'hA600_0000);
    chk("nob_rd1_pre", rd1_n, 32'd5);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    #1;
    chk("byp_rd1_post", rd1_b, 32'hA600_0000);
    chk("nob_rd1_post", rd1_n, 32'hA600_0000);
    chk("byp_wcnt", wcnt_b, 32'd4);

    // Reset beats a simultaneous write and suppresses bypass.
    drive(1'b0, 1'b1, 5'd4, 32'd6, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd4, 32'd1, 5'd4, 5'd4);
    #1;
    chk("rstw_rd1_during", rd1_b, 32'd6);
    chk("rstw_rd2_during", rd2_b, 32'd6);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
    #1;
    chk("rstw_rd1_after", rd1_b, 32'd0);
    chk("rstw_wcnt", wcnt_b, 32'd0);
    chk("rstw_wcnt_nob", wcnt_n, 32'd0);

    // Full sweep.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      #1;
      v1 = 32'(i) * 32'h0101_0101;
      v2 = 32'(31 - i) * 32'h0101_0101;
      chk("sweep_rd1", rd1_b, v1);
      chk("sweep_rd2", rd2_b, v2);
      tick();
    end
    chk("sweep_r31", rd1_n, 32'h1F1F_1F1F);
    chk("sweep_wcnt", wcnt_b, 32'd31);

    // Randomized traffic with occasional resets; forced hazards on read addresses.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, ra1, ra2;
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), wa, $urandom, ra1, ra2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
